// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
//   serial_state_t : 2-bit FSM state encoding {IDLE, SUB, DONE}
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : bit-counter width able to hold 0..width
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module serial_fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when b exceeds a, or when a==b and a borrow came in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = in1 - in2 (mod 2^WIDTH),
// one bit per clock, LSB first, through a single full-subtractor cell.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in1, in2   : minuend / subtrahend, sampled when a start is accepted
//   st         : start request (accepted in IDLE or DONE, ignored while busy)
//   busy       : high for exactly WIDTH cycles while bits are processed
//   done       : high while a valid result is held
//   diff       : result, 0 when done=0
//   bout       : unsigned borrow out of the MSB, 0 when done=0
//   ovf        : (SERIAL_SUB_OVF_EN only) signed overflow, 0 when done=0
// Handshake: st is a level sampled on each rising edge while the block is in
// IDLE or DONE; a sampled 1 starts a run with the in1/in2 present on that edge.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             st,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SUB  = SUB;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             bor_q;
    logic [CW-1:0]    cnt_q;
    logic             cell_d;
    logic             cell_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    serial_fs_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a start just like IDLE so runs can chain.
                    if (st) begin
                        a_q     <= in1;
                        b_q     <= in2;
                        r_q     <= '0;
                        bor_q   <= 1'b0;
                        cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    // Result bits enter at the MSB so bit 0 lands at R[0] after WIDTH shifts.
                    r_q   <= {cell_d, r_q[WIDTH-1:1]};
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    bor_q <= cell_bout;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit a_q[0]/b_q[0] are the operand sign bits.
                        ovf_q   <= (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_SUB);
    assign done = (state_q == ST_DONE);
    assign diff = done ? r_q : '0;
    assign bout = done & bor_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = done & ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=32). Define SERIAL_SUB_OVF_EN
// for both DUT and bench to include the overflow checks.
module tb_serial_subtractor;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         st;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .st    (st),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Presents operands with st for one rising edge, then scrambles the inputs
    // so any late sampling would corrupt the result. Returns at the negedge after E.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        st  = 1'b1;
        in1 = a;
        in2 = b;
        @(negedge clk);
        st  = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
    endtask

    // Waits (bounded) for done, counting negedges on which busy was seen.
    task automatic wait_done(input int budget, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        st    = 1'b0;
        in1   = '0;
        in2   = '0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, diff, bout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h bout=%b, required all 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int bc;
        start_op(32'd5, 32'd3);
        wait_done(100, bc);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done: done=%b after timeout, required 1", done);
        end
        n_cmp++;
        if (bc !== W) begin
            n_err++;
            $display("FAIL basic_busy_len: busy for %0d cycles, required %0d", bc, W);
        end
        n_cmp++;
        if ({diff, bout} !== {32'h0000_0002, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: diff=%h bout=%b, required 00000002 0", diff, bout);
        end
        // Result must hold while st stays low.
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({done, busy, diff, bout} !== {1'b1, 1'b0, 32'h0000_0002, 1'b0}) begin
            n_err++;
            $display("FAIL basic_hold: done=%b busy=%b diff=%h bout=%b, required 1 0 00000002 0",
                     done, busy, diff, bout);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vd [5];
        logic         vbo[5];
        int           bc;
        va[0] = 32'd3;          vb[0] = 32'd5;          vd[0] = 32'hFFFF_FFFE; vbo[0] = 1'b1;
        va[1] = 32'd0;          vb[1] = 32'd1;          vd[1] = 32'hFFFF_FFFF; vbo[1] = 1'b1;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'hFFFF_FFFF;  vd[2] = 32'h0000_0000; vbo[2] = 1'b0;
        va[3] = 32'h8000_0000;  vb[3] = 32'd1;          vd[3] = 32'h7FFF_FFFF; vbo[3] = 1'b0;
        va[4] = 32'h1234_5678;  vb[4] = 32'h0F0F_0F0F;  vd[4] = 32'h0325_4769; vbo[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_done(100, bc);
            n_cmp++;
            if ({done, diff, bout} !== {1'b1, vd[i], vbo[i]}) begin
                n_err++;
                $display("FAIL vector_%0d: done=%b diff=%h bout=%b, required 1 %h %b",
                         i, done, diff, bout, vd[i], vbo[i]);
            end
        end
    endtask

    task automatic test_ignore_mid();
        int bc;
        start_op(32'd100, 32'd37);
        repeat (9) @(negedge clk);
        st  = 1'b1;
        in1 = 32'd7;
        in2 = 32'd9;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end
        @(negedge clk);
        st = 1'b0;
        wait_done(100, bc);
        n_cmp++;
        if ({done, diff, bout} !== {1'b1, 32'd63, 1'b0}) begin
            n_err++;
            $display("FAIL mid_ignored: done=%b diff=%h bout=%b, required 1 0000003f 0",
                     done, diff, bout);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        // Entered with done=1 from the previous run.
        start_op(32'd7, 32'd7);
        n_cmp++;
        if ({done, busy, diff} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL b2b_restart: done=%b busy=%b diff=%h, required 0 1 0", done, busy, diff);
        end
        wait_done(100, bc);
        n_cmp++;
        if ({done, diff, bout} !== {1'b1, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_result: done=%b diff=%h bout=%b, required 1 0 0", done, diff, bout);
        end
        n_cmp++;
        if (bc !== W) begin
            n_err++;
            $display("FAIL b2b_busy_len: busy for %0d cycles, required %0d", bc, W);
        end
    endtask

    task automatic test_async_reset();
        int bc;
        start_op(32'h0000_1234, 32'h0000_0010);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, diff, bout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b, required all 0",
                     busy, done, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'd10, 32'd4);
        wait_done(100, bc);
        n_cmp++;
        if ({done, diff, bout} !== {1'b1, 32'd6, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset: done=%b diff=%h bout=%b, required 1 00000006 0",
                     done, diff, bout);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] vd [3];
        logic         vbo[3];
        logic         vo [3];
        int           bc;
        va[0] = 32'h8000_0000; vb[0] = 32'd1;          vd[0] = 32'h7FFF_FFFF; vbo[0] = 1'b0; vo[0] = 1'b1;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'hFFFF_FFFF;  vd[1] = 32'h8000_0000; vbo[1] = 1'b1; vo[1] = 1'b1;
        va[2] = 32'd5;         vb[2] = 32'd3;          vd[2] = 32'h0000_0002; vbo[2] = 1'b0; vo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            n_cmp++;
            if (ovf !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_busy_%0d: ovf=%b while busy, required 0", i, ovf);
            end
            wait_done(100, bc);
            n_cmp++;
            if ({done, diff, bout, ovf} !== {1'b1, vd[i], vbo[i], vo[i]}) begin
                n_err++;
                $display("FAIL ovf_vector_%0d: done=%b diff=%h bout=%b ovf=%b, required 1 %h %b %b",
                         i, done, diff, bout, ovf, vd[i], vbo[i], vo[i]);
            end
        end
    endtask
`endif

    // Operand pairs checked against a reference model via an expected queue.
    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic         exp_b_q[$];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic         eb;
        int           bc;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            exp_q.push_back(a - b);
            exp_b_q.push_back(a < b);
            start_op(a, b);
            wait_done(100, bc);
            e  = exp_q.pop_front();
            eb = exp_b_q.pop_front();
            n_cmp++;
            if ({done, diff, bout} !== {1'b1, e, eb}) begin
                n_err++;
                $display("FAIL random_%0d: %h-%h done=%b diff=%h bout=%b, required 1 %h %b",
                         i, a, b, done, diff, bout, e, eb);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (ovf !== ((a[W-1] != b[W-1]) && (e[W-1] != a[W-1]))) begin
                n_err++;
                $display("FAIL random_ovf_%0d: %h-%h ovf=%b", i, a, b, ovf);
            end
`endif
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_mid();
        test_back_to_back();
        test_async_reset();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
